freq_meter: RTL and testbench

//  Measures an incoming square wave sigin against clockin. Reports period and high

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/freq_meter_sync_edge_det.sv | 31 +++
 rtl/freq_meter.sv | 90 +++++++++
 tb/tb_freq_meter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default sizing.
package freq_meter_pkg;

  localparam int unsigned DefaultWidth      = 16;
  localparam int unsigned DefaultSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StMeas = 2'd2
  } meter_state_e;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, with a synchronized level and a
// single-cycle rising-edge pulse.
module freq_meter_sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int unsigned SyncStages = DefaultSyncStages
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  level_d1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      level_d1_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SyncStages-2:0], sig_i};
      level_d1_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = sync_q[SyncStages-1] & ~level_d1_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of an asynchronous square wave in clock cycles,
// strobing dataout_valid_o once per completed period.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned Width      = DefaultWidth,
  parameter int unsigned SyncStages = DefaultSyncStages
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             sigin_i,
  output logic [Width-1:0] period_o,
  output logic [Width-1:0] high_time_o,
  output logic             dataout_valid_o,
  output logic             overflow_o
);

  localparam logic [Width-1:0] CntMax = '1;
  localparam logic [Width-1:0] CntOne = {{(Width-1){1'b0}}, 1'b1};

  logic level, rise;

  freq_meter_sync_edge_det #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (sigin_i),
    .level_o(level),
    .rise_o (rise)
  );

  meter_state_e     state_q;
  logic [Width-1:0] cnt_q, hcnt_q;
  logic [Width-1:0] period_q, high_q;
  logic             valid_q, ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!enable_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StArm;
          StArm: begin
            if (rise) begin
              state_q <= StMeas;
              cnt_q   <= CntOne;
              hcnt_q  <= CntOne;
            end
          end
          StMeas: begin
            // A rise on the timeout cycle still closes a valid period of CntMax.
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= hcnt_q;
              valid_q  <= 1'b1;
              ovf_q    <= 1'b0;
              cnt_q    <= CntOne;
              hcnt_q   <= CntOne;
            end else if (cnt_q == CntMax) begin
              state_q <= StArm;
              ovf_q   <= 1'b1;
            end else begin
              cnt_q  <= cnt_q + CntOne;
              hcnt_q <= hcnt_q + {{(Width-1){1'b0}}, level};
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign period_o        = period_q;
  assign high_time_o     = high_q;
  assign dataout_valid_o = valid_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (Width=8): table-driven waveforms with a strobe
// scoreboard, plus hand sequences for reset, timeout, enable drop and mid-run reset.
module tb_freq_meter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         sigin;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         dataout_valid;
  logic         overflow;

  freq_meter #(
    .Width     (W),
    .SyncStages(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .sigin_i        (sigin),
    .period_o       (period),
    .high_time_o    (high_time),
    .dataout_valid_o(dataout_valid),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned h;
  } exp_t;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    int unsigned n;
    int unsigned exp_p;
    int unsigned exp_h;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int unsigned p, input int unsigned h);
    exp_t x;
    x.p = p;
    x.h = h;
    exp_q.push_back(x);
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    sigin = 1'b1;
    repeat (hi) @(negedge clk);
    sigin = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Leave the meter idle with sigin low, then re-arm it.
  task automatic restart();
    sigin  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dataout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe period=%0d high=%0d, required none",
                 period, high_time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_period", int'(period), int'(e.p));
        check("strobe_high_time", int'(high_time), int'(e.h));
        check("strobe_overflow", int'(overflow), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    sigin  = 1'b0;

    // Reset with sigin toggling: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      sigin = ~sigin;
      @(negedge clk);
      check("reset_period", int'(period), 0);
      check("reset_high_time", int'(high_time), 0);
      check("reset_valid", int'(dataout_valid), 0);
      check("reset_overflow", int'(overflow), 0);
    end
    rst   = 1'b0;
    sigin = 1'b0;

    vecs[0] = '{hi: 5,  lo: 5,  n: 4, exp_p: 10, exp_h: 5};
    vecs[1] = '{hi: 3,  lo: 9,  n: 3, exp_p: 12, exp_h: 3};
    vecs[2] = '{hi: 1,  lo: 1,  n: 4, exp_p: 2,  exp_h: 1};
    vecs[3] = '{hi: 7,  lo: 2,  n: 3, exp_p: 9,  exp_h: 7};
    vecs[4] = '{hi: 1,  lo: 19, n: 2, exp_p: 20, exp_h: 1};
    vecs[5] = '{hi: 12, lo: 3,  n: 2, exp_p: 15, exp_h: 12};

    for (int v = 0; v < 6; v++) begin
      restart();
      pulse(vecs[v].hi, vecs[v].lo);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        push(vecs[v].exp_p, vecs[v].exp_h);
        pulse(vecs[v].hi, vecs[v].lo);
      end
      drain("table_all_strobes_seen");
    end

    // One rise then stuck low: overflow exactly after the counter saturates.
    restart();
    sigin = 1'b1;
    repeat (3) @(negedge clk);
    sigin = 1'b0;
    repeat (254) @(negedge clk);
    check("overflow_not_early", int'(overflow), 0);
    @(negedge clk);
    check("overflow_set", int'(overflow), 1);
    // Back in ARM: first rise arms, then a 20-cycle and a full-scale 255-cycle period.
    pulse(4, 16);
    push(20, 4);
    pulse(4, 251);
    push(255, 4);
    pulse(4, 16);
    drain("overflow_recovery_strobes");
    check("overflow_cleared", int'(overflow), 0);

    // Enable dropped for one cycle mid-period: that period is lost, two rises to recover.
    restart();
    pulse(5, 5);
    push(10, 5);
    pulse(5, 5);
    push(10, 5);
    pulse(5, 2);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("enable_drop_holds_period", int'(period), 10);
    pulse(5, 5);
    push(10, 5);
    pulse(5, 5);
    drain("enable_drop_strobes");

    // Reset mid-measurement: outputs clear next cycle, then resume after two rises.
    restart();
    pulse(3, 7);
    push(10, 3);
    pulse(3, 4);
    check("pre_reset_period", int'(period), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_period", int'(period), 0);
    check("midrun_reset_high_time", int'(high_time), 0);
    check("midrun_reset_valid", int'(dataout_valid), 0);
    check("midrun_reset_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    pulse(5, 5);
    push(10, 5);
    pulse(5, 5);
    drain("post_reset_strobes");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
